// File: rtl/cipher_pkg.sv
// Shared constants and state encoding for the streaming Vigenere cipher engine.
package cipher_pkg;

  localparam logic [7:0] CHAR_A   = 8'd65;
  localparam logic [7:0] CHAR_Z   = 8'd90;
  localparam int         ALPHA_N  = 26;
  localparam logic       MODE_ENC = 1'b0;
  localparam logic       MODE_DEC = 1'b1;

  typedef enum logic {
    NOKEY = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic isUpper(input logic [7:0] c);
    return (c >= CHAR_A) && (c <= CHAR_Z);
  endfunction

endpackage

// File: rtl/caesar_shift_unit.sv
// Combinational single-letter Caesar shift: rotates 'A'..'Z' by shift, passes anything else through.
module caesar_shift_unit
  import cipher_pkg::*;
(
  input  logic [7:0] inChar,
  input  logic [4:0] shift,
  input  logic       mode,
  output logic [7:0] outChar,
  output logic       isLetter
);

  logic [5:0] p;
  logic [5:0] sum;
  logic [5:0] diff;
  logic [5:0] s;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    isLetter = isUpper(inChar);
    p        = 6'(inChar - CHAR_A);
    sum      = p + {1'b0, shift};
    diff     = p - {1'b0, shift};
    s        = sum;
    if (mode == MODE_ENC) begin
      if (sum >= 6'(ALPHA_N)) s = sum - 6'(ALPHA_N);
    end else begin
      // Borrow out of p-k means the result wrapped below 'A'.
      s = (p < {1'b0, shift}) ? diff + 6'(ALPHA_N) : diff;
    end
    outChar = isLetter ? ({2'b00, s} + CHAR_A) : inChar;
  end

endmodule

// File: rtl/vigenere_stream_engine.sv
// Streaming Vigenere encrypt/decrypt engine: key registers, key index counter,
// NOKEY/RUN control and a one-entry output register around a Caesar shift unit.
module vigenere_stream_engine
  import cipher_pkg::*;
#(
  parameter int KEY_MAX = 10,
  parameter int LEN_W   = $clog2(KEY_MAX + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 key_load,
  input  logic [8*KEY_MAX-1:0] key_in,
  input  logic [LEN_W-1:0]     key_len,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_char,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 key_err,
  output logic [LEN_W-1:0]     key_idx
);

  state_t               state;
  state_t               stateNext;
  logic [8*KEY_MAX-1:0] keyReg;
  logic [LEN_W-1:0]     keyLenReg;
  logic                 modeReg;

  logic                 lenOk;
  logic [LEN_W-1:0]     byteSel;
  logic [7:0]           keyChar;
  logic [4:0]           shift;
  logic [7:0]           cipherChar;
  logic                 charIsLetter;
  logic                 accept;
  logic                 idxWrap;

  assign lenOk   = (key_len != '0) && (key_len <= LEN_W'(KEY_MAX));
  assign in_ready = (state == RUN) && !key_load && (!out_valid || out_ready);
  assign accept  = in_valid && in_ready;
  assign idxWrap = (key_idx == keyLenReg - LEN_W'(1));

  // First key character lives in the highest used byte, so walk downwards from there.
  assign byteSel = keyLenReg - LEN_W'(1) - key_idx;

  always_comb begin
    keyChar = '0;
    for (int i = 0; i < KEY_MAX; i++) begin
      if (byteSel == LEN_W'(i)) keyChar = keyReg[8*i +: 8];
    end
    shift = isUpper(keyChar) ? 5'(keyChar - CHAR_A) : 5'd0;
  end

  caesar_shift_unit u_shift (
    .inChar  (in_char),
    .shift   (shift),
    .mode    (modeReg),
    .outChar (cipherChar),
    .isLetter(charIsLetter)
  );

  always_comb begin
    stateNext = state;
    if (key_load) stateNext = lenOk ? RUN : NOKEY;
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= NOKEY;
    else       state <= stateNext;
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: the key store is only a few flops, so it is cleared by reset like the rest of the state.
    if (reset) begin
      keyReg    <= '0;
      keyLenReg <= '0;
      modeReg   <= MODE_ENC;
      key_err   <= 1'b0;
    end else if (key_load) begin
      key_err <= !lenOk;
      if (lenOk) begin
        keyReg    <= key_in;
        keyLenReg <= key_len;
        modeReg   <= mode;
      end
    end
  end

  // A key load abandons whatever is in flight and restarts at the first key character.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_char  <= '0;
      key_idx   <= '0;
    end else if (key_load) begin
      out_valid <= 1'b0;
      key_idx   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_char  <= cipherChar;
      if (charIsLetter) key_idx <= idxWrap ? '0 : key_idx + LEN_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vigenere_stream_engine.sv
// Self-checking bench for vigenere_stream_engine: fixed vector table, hand-written
// corner sequences and randomized streams scored against a mod-26 reference model.
module tb_vigenere_stream_engine;

  localparam int KEY_MAX = 10;
  localparam int LEN_W   = 4;

  logic                 clock;
  logic                 reset;
  logic                 key_load;
  logic [8*KEY_MAX-1:0] key_in;
  logic [LEN_W-1:0]     key_len;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_char;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_char;
  logic                 key_err;
  logic [LEN_W-1:0]     key_idx;

  vigenere_stream_engine #(.KEY_MAX(KEY_MAX), .LEN_W(LEN_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .key_load (key_load),
    .key_in   (key_in),
    .key_len  (key_len),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_char (out_char),
    .key_err  (key_err),
    .key_idx  (key_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checkCount = 0;
  int passCount  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  typedef struct packed {
    logic [79:0]  key;
    logic [3:0]   keyLen;
    logic         mode;
    logic [159:0] text;
    logic [4:0]   textLen;
    logic [159:0] expText;
  } vec_t;

  vec_t vecs[5];

  // Reference model: plain mod-26 arithmetic on letter positions.
  function automatic logic [7:0] modelChar(input logic [7:0] c, input logic [7:0] k, input logic m);
    int p;
    int kv;
    if (c < 8'd65 || c > 8'd90) return c;
    p  = int'(c) - 65;
    kv = (k >= 8'd65 && k <= 8'd90) ? int'(k) - 65 : 0;
    if (m) return 8'(65 + (p - kv + 26) % 26);
    return 8'(65 + (p + kv) % 26);
  endfunction

  task automatic loadKey(input logic [79:0] k, input logic [3:0] len, input logic m);
    @(posedge clock); #1;
    key_load = 1'b1;
    key_in   = k;
    key_len  = len;
    mode     = m;
    @(negedge clock);
    check("load_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    key_load = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int vi);
    int letters;
    logic [7:0] c;
    logic [7:0] e;
    letters = 0;
    loadKey(v.key, v.keyLen, v.mode);
    out_ready = 1'b1;
    for (int i = 0; i < int'(v.textLen); i++) begin
      c = v.text[8*(int'(v.textLen) - 1 - i) +: 8];
      if (c >= 8'd65 && c <= 8'd90) letters++;
      in_valid = 1'b1;
      in_char  = c;
      @(negedge clock);
      check($sformatf("v%0d_in_ready%0d", vi, i), 32'(in_ready), 32'd1);
      if (i > 0) begin
        e = v.expText[8*(int'(v.textLen) - i) +: 8];
        check($sformatf("v%0d_valid%0d", vi, i - 1), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_char%0d", vi, i - 1), 32'(out_char), 32'(e));
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    e = v.expText[7:0];
    check($sformatf("v%0d_valid_last", vi), 32'(out_valid), 32'd1);
    check($sformatf("v%0d_char_last", vi), 32'(out_char), 32'(e));
    check($sformatf("v%0d_key_idx", vi), 32'(key_idx), 32'(letters % int'(v.keyLen)));
  endtask

  task automatic randomRound(input int r);
    int len;
    logic [7:0] keyB[10];
    logic [79:0] kIn;
    logic m;
    logic [7:0] stream[60];
    logic [7:0] expQ[$];
    logic [7:0] e;
    int kIdx;
    int letters;
    int srcIdx;
    int got;
    int cycles;
    logic inFire;
    logic outFire;

    len = $urandom_range(1, 10);
    m   = 1'($urandom_range(0, 1));
    kIn = '0;
    for (int j = 0; j < len; j++) begin
      keyB[j] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(48, 57)) : 8'($urandom_range(65, 90));
      kIn[8*(len - 1 - j) +: 8] = keyB[j];
    end
    kIdx    = 0;
    letters = 0;
    for (int i = 0; i < 60; i++) begin
      stream[i] = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(65, 90)) : 8'($urandom_range(32, 126));
      expQ.push_back(modelChar(stream[i], keyB[kIdx], m));
      if (stream[i] >= 8'd65 && stream[i] <= 8'd90) begin
        kIdx = (kIdx + 1) % len;
        letters++;
      end
    end

    loadKey(kIn, 4'(len), m);
    srcIdx    = 0;
    got       = 0;
    cycles    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while (got < 60 && cycles < 2000) begin
      @(negedge clock);
      inFire  = in_valid && in_ready;
      outFire = out_valid && out_ready;
      if (outFire) begin
        e = expQ.pop_front();
        check($sformatf("rnd%0d_out%0d", r, got), 32'(out_char), 32'(e));
        got++;
      end
      @(posedge clock); #1;
      cycles++;
      if (inFire) srcIdx++;
      if (srcIdx < 60) begin
        if (!(in_valid && !inFire)) in_valid = ($urandom_range(0, 3) != 0);
        in_char = stream[srcIdx];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("rnd%0d_all_received", r), 32'(got), 32'd60);
    check($sformatf("rnd%0d_key_idx", r), 32'(key_idx), 32'(letters % len));
  endtask

  initial begin
    reset     = 1'b1;
    key_load  = 1'b0;
    key_in    = '0;
    key_len   = '0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_char   = '0;
    out_ready = 1'b0;

    vecs[0].key = 80'("KADIROZLEM"); vecs[0].keyLen = 4'd10; vecs[0].mode = 1'b0;
    vecs[0].text = 160'("ISTANBULTECHNICAL"); vecs[0].textLen = 5'd17;
    vecs[0].expText = 160'("SSWIEPTWXQMHQQTOK");
    vecs[1].key = 80'("KADIROZLEM"); vecs[1].keyLen = 4'd10; vecs[1].mode = 1'b1;
    vecs[1].text = 160'("SSWIEPTWXQMHQQTOK"); vecs[1].textLen = 5'd17;
    vecs[1].expText = 160'("ISTANBULTECHNICAL");
    vecs[2].key = 80'("AB"); vecs[2].keyLen = 4'd2; vecs[2].mode = 1'b0;
    vecs[2].text = 160'("A A"); vecs[2].textLen = 5'd3;
    vecs[2].expText = 160'("A B");
    vecs[3].key = 80'("A1C"); vecs[3].keyLen = 4'd3; vecs[3].mode = 1'b0;
    vecs[3].text = 160'("ZZZZ"); vecs[3].textLen = 5'd4;
    vecs[3].expText = 160'("ZZBZ");
    vecs[4].key = 80'("Z"); vecs[4].keyLen = 4'd1; vecs[4].mode = 1'b1;
    vecs[4].text = 160'("AZ!b"); vecs[4].textLen = 5'd4;
    vecs[4].expText = 160'("BA!b");

    // Reset state, sampled between edges while reset is held.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_char", 32'(out_char), 32'd0);
    check("rst_key_idx", 32'(key_idx), 32'd0);
    check("rst_key_err", 32'(key_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_char  = "A";
    @(negedge clock);
    check("nokey_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;

    for (int v = 0; v < 5; v++) runVector(vecs[v], v);

    // Backpressure: output held while the sink stalls, nothing lost or duplicated.
    loadKey(80'("KADIROZLEM"), 4'd10, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_char   = "I";
    @(posedge clock); #1;
    in_char   = "T";
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      check($sformatf("bp_valid%0d", s), 32'(out_valid), 32'd1);
      check($sformatf("bp_char%0d", s), 32'(out_char), 32'("S"));
      check($sformatf("bp_in_ready%0d", s), 32'(in_ready), 32'd0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_char", 32'(out_char), 32'("T"));
    @(posedge clock); #1;
    @(negedge clock);
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_key_idx", 32'(key_idx), 32'd2);

    // Bad key lengths force NOKEY; a good load clears the error.
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_char  = "A";
    loadKey(80'("AB"), 4'd0, 1'b0);
    @(negedge clock);
    check("bad0_key_err", 32'(key_err), 32'd1);
    check("bad0_in_ready", 32'(in_ready), 32'd0);
    loadKey(80'("AB"), 4'd11, 1'b0);
    @(negedge clock);
    check("bad11_key_err", 32'(key_err), 32'd1);
    check("bad11_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    loadKey(80'("AB"), 4'd2, 1'b0);
    @(negedge clock);
    check("good_key_err", 32'(key_err), 32'd0);
    check("good_key_idx", 32'(key_idx), 32'd0);
    check("good_in_ready", 32'(in_ready), 32'd1);

    // Reload with a pending output discards it and restarts the key.
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_char   = "C";
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("reload_pre_valid", 32'(out_valid), 32'd1);
    check("reload_pre_idx", 32'(key_idx), 32'd1);
    loadKey(80'("AB"), 4'd2, 1'b0);
    @(negedge clock);
    check("reload_valid", 32'(out_valid), 32'd0);
    check("reload_idx", 32'(key_idx), 32'd0);
    out_ready = 1'b1;

    for (int r = 0; r < 4; r++) randomRound(r);

    // Asynchronous reset between edges clears outputs without waiting for a clock.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_char   = "C";
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check("areset_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_out_char", 32'(out_char), 32'd0);
    check("areset_key_idx", 32'(key_idx), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_char  = "A";
    @(negedge clock);
    check("areset_nokey_in_ready", 32'(in_ready), 32'd0);
    check("areset_key_err", 32'(key_err), 32'd0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
